// File: rtl/traffic_scheduler.sv
// Per-frame car motion sweep: updates one car X per clock after an accepted frame_tick.
// Positions only change during the 6-cycle UPDATE burst, so the renderer sees stable registers.
module traffic_scheduler #(
  parameter int H_ACTIVE    = 640,
  parameter int GRID_HEIGHT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [2:0] level,
  input  logic       restart,
  output logic [9:0] carX_1,
  output logic [9:0] carX_2,
  output logic [9:0] carX_3,
  output logic [9:0] carX_4,
  output logic [9:0] carX_5,
  output logic [9:0] carX_6,
  output logic [8:0] carY_1,
  output logic [8:0] carY_2,
  output logic [8:0] carY_3,
  output logic [8:0] carY_4,
  output logic [8:0] carY_5,
  output logic [8:0] carY_6,
  output logic       busy,
  output logic       sweep_done
);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  idx;
  logic [2:0]  level_q;
  logic [9:0]  car_x [6];
  logic [8:0]  car_y [6];
  logic        start, upd;
  logic [3:0]  spd;
  logic [10:0] cur, sum, x_next;

  function automatic logic [9:0] init_x(input int k);
    case (k)
      0:       return 10'd0;
      1:       return 10'd200;
      2:       return 10'd400;
      3:       return 10'd576;
      4:       return 10'd376;
      default: return 10'd176;
    endcase
  endfunction

  function automatic logic [3:0] base_speed(input logic [2:0] k);
    case (k)
      3'd0:    return 4'd1;
      3'd1:    return 4'd2;
      3'd2:    return 4'd3;
      3'd3:    return 4'd2;
      3'd4:    return 4'd1;
      default: return 4'd3;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || restart) state <= IDLE;
    else                   state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    upd        = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick && run) begin
          state_next = UPDATE;
          start      = 1'b1;
        end
      end
      UPDATE: begin
        upd = 1'b1;
        if (idx == 3'd5) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cars 0..2 move right, 3..5 move left; all sums kept at 11 bits before wrapping.
  always_comb begin
    spd    = base_speed(idx) + {1'b0, level_q};
    cur    = {1'b0, car_x[(idx > 3'd5) ? 3'd0 : idx]};
    sum    = cur + 11'(spd);
    x_next = '0;
    if (idx < 3'd3) begin
      x_next = (sum >= 11'(H_ACTIVE)) ? sum - 11'(H_ACTIVE) : sum;
    end else begin
      x_next = (cur < 11'(spd)) ? cur + 11'(H_ACTIVE) - 11'(spd) : cur - 11'(spd);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      for (int k = 0; k < 6; k++) car_x[k] <= init_x(k);
      idx        <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      if (!rst_n) level_q <= '0;
    end else begin
      busy       <= (state_next == UPDATE);
      sweep_done <= (state_next == DONE);
      if (start) begin
        idx     <= '0;
        level_q <= level;
      end else if (upd) begin
        car_x[idx] <= x_next[9:0];
        idx        <= idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) car_y[k] <= 9'(2 * (k + 1) * GRID_HEIGHT);
    end
  end

  assign carX_1 = car_x[0];
  assign carX_2 = car_x[1];
  assign carX_3 = car_x[2];
  assign carX_4 = car_x[3];
  assign carX_5 = car_x[4];
  assign carX_6 = car_x[5];
  assign carY_1 = car_y[0];
  assign carY_2 = car_y[1];
  assign carY_3 = car_y[2];
  assign carY_4 = car_y[3];
  assign carY_5 = car_y[4];
  assign carY_6 = car_y[5];

endmodule

// File: tb/tb_traffic_scheduler.sv
// Bench for traffic_scheduler: directed scenarios plus randomized sweeps against a modular-arithmetic model.
module tb_traffic_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, run, restart;
  logic [2:0] level;
  logic [9:0] carX_1, carX_2, carX_3, carX_4, carX_5, carX_6;
  logic [8:0] carY_1, carY_2, carY_3, carY_4, carY_5, carY_6;
  logic       busy, sweep_done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  int init_x [6] = '{0, 200, 400, 576, 376, 176};
  int base   [6] = '{1, 2, 3, 2, 1, 3};
  int lane_y [6] = '{64, 128, 192, 256, 320, 384};
  int mx     [6];

  traffic_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .level(level),
    .restart(restart),
    .carX_1(carX_1), .carX_2(carX_2), .carX_3(carX_3),
    .carX_4(carX_4), .carX_5(carX_5), .carX_6(carX_6),
    .carY_1(carY_1), .carY_2(carY_2), .carY_3(carY_3),
    .carY_4(carY_4), .carY_5(carY_5), .carY_6(carY_6),
    .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sweep_done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  function automatic int get_x(input int k);
    case (k)
      0:       return int'(carX_1);
      1:       return int'(carX_2);
      2:       return int'(carX_3);
      3:       return int'(carX_4);
      4:       return int'(carX_5);
      default: return int'(carX_6);
    endcase
  endfunction

  function automatic int get_y(input int k);
    case (k)
      0:       return int'(carY_1);
      1:       return int'(carY_2);
      2:       return int'(carY_3);
      3:       return int'(carY_4);
      4:       return int'(carY_5);
      default: return int'(carY_6);
    endcase
  endfunction

  // One frame of motion on the whole road, expressed as modular position arithmetic.
  function automatic int move(input int x, input int k, input int lvl);
    int s;
    s = base[k] + lvl;
    if (k < 3) return (x + s) % 640;
    return (x - s + 640) % 640;
  endfunction

  task automatic model_reload();
    for (int k = 0; k < 6; k++) mx[k] = init_x[k];
  endtask

  task automatic model_sweep(input int lvl);
    for (int k = 0; k < 6; k++) mx[k] = move(mx[k], k, lvl);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    model_reload();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; restart = 1'b0; level = 3'd0;
    step(2);
    rst_n = 1'b1;
    model_reload();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (get_x(k) !== init_x[k]) begin
        errors++;
        $display("FAIL reset_x car%0d: got %0d expected %0d", k + 1, get_x(k), init_x[k]);
      end
      checks++;
      if (get_y(k) !== lane_y[k]) begin
        errors++;
        $display("FAIL reset_y car%0d: got %0d expected %0d", k + 1, get_y(k), lane_y[k]);
      end
    end
    checks++;
    if (busy !== 1'b0 || sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, sweep_done);
    end
  endtask

  task automatic test_single_sweep();
    int prev [6];
    for (int k = 0; k < 6; k++) prev[k] = mx[k];
    model_sweep(0);
    run = 1'b1; level = 3'd0; frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (busy !== ((c >= 1 && c <= 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL sweep_busy t+%0d: got %b expected %b", c, busy, (c <= 6));
      end
      checks++;
      if (sweep_done !== ((c == 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL sweep_done t+%0d: got %b expected %b", c, sweep_done, (c == 7));
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if (get_x(c - 2) !== mx[c - 2]) begin
          errors++;
          $display("FAIL sweep_car%0d t+%0d: got %0d expected %0d", c - 1, c, get_x(c - 2), mx[c - 2]);
        end
        if (c <= 6) begin
          checks++;
          if (get_x(c - 1) !== prev[c - 1]) begin
            errors++;
            $display("FAIL sweep_early_car%0d t+%0d: got %0d expected %0d", c, c, get_x(c - 1), prev[c - 1]);
          end
        end
      end
      step(1);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (get_x(k) !== mx[k]) begin
        errors++;
        $display("FAIL sweep_final car%0d: got %0d expected %0d", k + 1, get_x(k), mx[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int d0;
    int exp_x [6] = '{192, 416, 0, 360, 184, 576};
    do_restart();
    d0 = done_cnt;
    run = 1'b1; level = 3'd7;
    for (int i = 0; i < 24; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(19);
      model_sweep(7);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (get_x(k) !== exp_x[k] || get_x(k) !== mx[k]) begin
        errors++;
        $display("FAIL wrap car%0d: got %0d expected %0d", k + 1, get_x(k), exp_x[k]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 24) begin
      errors++;
      $display("FAIL wrap_done_count: got %0d expected 24", done_cnt - d0);
    end
  endtask

  task automatic test_run_disabled();
    int d0, b0;
    d0 = done_cnt; b0 = busy_cnt;
    run = 1'b0; level = 3'd5;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(9);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (get_x(k) !== mx[k]) begin
        errors++;
        $display("FAIL norun car%0d: got %0d expected %0d", k + 1, get_x(k), mx[k]);
      end
    end
    checks++;
    if (busy_cnt != b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL norun_activity: got busy_cycles=%0d done_pulses=%0d expected 0 0", busy_cnt - b0, done_cnt - d0);
    end
  endtask

  task automatic test_restart_mid();
    int d0;
    do_restart();
    run = 1'b1; level = 3'd4; frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(2);
    d0 = done_cnt;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    model_reload();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (get_x(k) !== init_x[k]) begin
        errors++;
        $display("FAIL restart_x car%0d: got %0d expected %0d", k + 1, get_x(k), init_x[k]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_busy: got %b expected 0", busy);
    end
    step(6);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL restart_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
    level = 3'd2; frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(9);
    model_sweep(2);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (get_x(k) !== mx[k]) begin
        errors++;
        $display("FAIL restart_resweep car%0d: got %0d expected %0d", k + 1, get_x(k), mx[k]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL restart_resweep_done: got %0d pulses expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_extra_tick();
    int d0;
    do_restart();
    d0 = done_cnt;
    run = 1'b1; level = 3'd0; frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(3);
    checks++;
    if (sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL extra_done_t6: got %b expected 0", sweep_done);
    end
    step(1);
    checks++;
    if (sweep_done !== 1'b1) begin
      errors++;
      $display("FAIL extra_done_t7: got %b expected 1", sweep_done);
    end
    step(10);
    model_sweep(0);
    checks++;
    if (get_x(0) !== 1 || get_x(0) !== mx[0]) begin
      errors++;
      $display("FAIL extra_car1: got %0d expected 1", get_x(0));
    end
    for (int k = 1; k < 6; k++) begin
      checks++;
      if (get_x(k) !== mx[k]) begin
        errors++;
        $display("FAIL extra_car%0d: got %0d expected %0d", k + 1, get_x(k), mx[k]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL extra_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_random();
    int d0, lvl, extra, exp_done;
    bit r;
    do_restart();
    for (int i = 0; i < 40; i++) begin
      d0 = done_cnt;
      lvl = $urandom_range(0, 7);
      r = ($urandom_range(0, 3) != 0);
      extra = $urandom_range(0, 6);
      run = r; level = 3'(lvl); frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      level = 3'($urandom_range(0, 7));
      if (extra > 0) begin
        step(extra - 1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(8 - extra);
      end else begin
        step(8);
      end
      exp_done = r ? 1 : 0;
      if (r) model_sweep(lvl);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (get_x(k) !== mx[k]) begin
          errors++;
          $display("FAIL random%0d car%0d: got %0d expected %0d", i, k + 1, get_x(k), mx[k]);
        end
      end
      checks++;
      if (done_cnt - d0 != exp_done) begin
        errors++;
        $display("FAIL random%0d done: got %0d expected %0d", i, done_cnt - d0, exp_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_wrap();
    test_run_disabled();
    test_restart_mid();
    test_extra_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

Per-frame motion controller for the six road cars. It sweeps the car positions once per frame during vertical blanking, updating one car per clock, and drives the registered `carX_n`/`carY_n` inputs of the VGA renderer. Positions therefore never change while a visible line is being drawn.

## Interface
Parameters:
- `H_ACTIVE`, default 640: horizontal wrap modulus in pixels.
- `GRID_HEIGHT`, default 32: lane row height in pixels.

Ports:
- `clk`, in, 1: system clock, the same clock as the VGA block. Single clock domain.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `frame_tick`, in, 1: one-cycle pulse at start of vertical blanking.
- `run`, in, 1: motion enable, sampled only on an accepted `frame_tick`.
- `level`, in, 3: difficulty 0..7, sampled on an accepted `frame_tick` and held for the sweep.
- `restart`, in, 1: one-cycle pulse that reloads the initial positions.
- `carX_1`..`carX_6`, out, 10 each: car left-edge X, registered.
- `carY_1`..`carY_6`, out, 9 each: car top-edge Y, registered, constant after reset.
- `busy`, out, 1: high while the sweep is in progress.
- `sweep_done`, out, 1: one-cycle pulse when a sweep completes.

## Operation
- **Lanes (fixed Y):** car k sits in grid row 2k, so `carY_k = 2k*GRID_HEIGHT`: 64, 128, 192, 256, 320, 384.
- **Initial X:** car1 0, car2 200, car3 400, car4 576, car5 376, car6 176.
- **Direction:**
  - Cars 1-3 move right (+).
  - Cars 4-6 move left (-).
- **Speed:** speed_k = BASE_k + level_latched. BASE = 1, 2, 3, 2, 1, 3 for cars 1..6. Range is 1..10 px/frame.
- **Arithmetic:** computed at 11 bits, result always in 0..H_ACTIVE-1.
  - Right-moving: s = X + speed. If s >= H_ACTIVE then X <= s - H_ACTIVE, else X <= s.
  - Left-moving: if X < speed then X <= X + H_ACTIVE - speed, else X <= X - speed.
- **FSM:** IDLE, UPDATE, DONE.
  - IDLE -> UPDATE on `frame_tick & run`. On entry: latch `level`, set idx = 0.
  - UPDATE: car idx+1 is updated at the clock edge ending the cycle; idx increments. After idx = 5, go to DONE.
  - DONE: assert `sweep_done` for that cycle, then go to IDLE.
- **`frame_tick` with `run` = 0:** ignored. No sweep, no pulse.
- **`frame_tick` while in UPDATE or DONE:** ignored. Exactly one sweep per accepted tick.
- **`restart`:** highest priority below reset, from any state.
  - At the next edge: all X reloaded to initial values, FSM to IDLE, idx = 0.
  - `sweep_done` is not asserted for an aborted sweep.
  - Simultaneous `restart` and `frame_tick`: `restart` wins and the tick is dropped.
- **`rst_n` low at an edge:** same effect as `restart`. In addition, `busy` = 0 and `sweep_done` = 0.
- **Reset values:**
  - `carX_k` = initial X values above.
  - `carY_k` = lane values above.
  - `busy` = 0, `sweep_done` = 0.
  - `level_latched` = 0, state IDLE.

## Timing
- `frame_tick` is sampled high in cycle t (state IDLE, `run` = 1).
- `busy` is high in cycles t+1..t+6 (state UPDATE). `busy` = (state == UPDATE), registered via state.
- Car k's new X is visible from cycle t+1+k; car6 updates in cycle t+7.
- `sweep_done` is high in cycle t+7 only (state DONE). `busy` is 0 in t+7. State is IDLE from t+8.
- Total latency from tick to last update is 7 cycles, far inside vertical blanking (45 lines).
- `restart` sampled in cycle r: reloaded X values are visible in r+1, `busy` = 0 in r+1.
- Outputs are only ever driven from registers. No combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles, then release.
  - Expect car1 (0, 64), car3 (400, 192), car6 (176, 384).
  - Expect `busy` = 0, `sweep_done` = 0.
- **Single sweep at level 0:** `run` = 1, `level` = 0, one `frame_tick` at t.
  - Expect X = 1, 202, 403, 574, 375, 173.
  - Expect `busy` high t+1..t+6 and `sweep_done` only at t+7.
- **Wrap at level 7:** `run` = 1, `level` = 7, 24 ticks spaced 20 cycles apart.
  - Car3: 400 + 240 wraps to 0.
  - Car1: 192.
  - Car6: 176 - 240 wraps to 576.
  - Car5: 376 - 192 = 184.
- **Motion disabled:** `run` = 0, 5 ticks.
  - All X unchanged, `busy` never high, no `sweep_done`.
- **Restart mid-sweep:** tick at t, then `restart` at t+3.
  - At t+4: all X at initial values, `busy` = 0.
  - No `sweep_done` at t+7.
  - Next tick performs a normal full sweep.
- **Extra tick during sweep:** ticks at t and t+2 (`level` = 0).
  - Exactly one increment applied (car1 X = 1).
  - Exactly one `sweep_done` pulse, at t+7.
